// File: rtl/scbuf_rdmard_burst.sv
// RDMA-read return engine: captures an ECC-protected L2 line, streams ctag + wrapping SEC-DED-corrected burst to JBI.
// Optional SCBUF_RDMARD_ERRCNT_EN adds saturating CE/UE beat counters; otherwise the counter ports read 0.
module scbuf_rdmard_burst #(
  parameter int NWORDS   = 16,
  parameter int WIDX_W   = 4,
  parameter int CTAG_W   = 15,
  parameter int IORD_BIT = 12
) (
  input  logic                 rclk,
  input  logic                 arst,
  input  logic                 sctag_scbuf_req_en_c7,
  input  logic [CTAG_W-1:0]    sctag_scbuf_ctag_c7,
  input  logic [WIDX_W-1:0]    sctag_scbuf_word_c7,
  input  logic [WIDX_W-1:0]    sctag_scbuf_len_m1_c7,
  input  logic [NWORDS*39-1:0] scdata_scbuf_decc_out_c7,
  input  logic                 jbi_scbuf_stall,
  output logic                 scbuf_sctag_rdmard_busy,
  output logic                 scbuf_jbi_ctag_vld,
  output logic                 scbuf_jbi_data_vld,
  output logic [31:0]          scbuf_jbi_data,
  output logic                 scbuf_jbi_ue_err,
  output logic                 scbuf_sctag_rdma_uerr,
  output logic                 scbuf_sctag_rdma_cerr,
  output logic                 scbuf_sctag_rdmard_ovf,
  output logic [7:0]           scbuf_rdmard_ce_cnt,
  output logic [7:0]           scbuf_rdmard_ue_cnt
);

  typedef enum logic [1:0] {IDLE, CTAG, DATA, DONE} state_t;

  state_t               state_q;
  logic [NWORDS*39-1:0] line_q;
  logic [CTAG_W-1:0]    ctag_q;
  logic [WIDX_W-1:0]    start_q, len_q;
  logic [WIDX_W:0]      cnt_q;
  logic                 ctag_vld_q, data_vld_q, ue_err_q, uerr_q, cerr_q, ovf_q;
  logic                 ue_acc_q, ce_acc_q;
  logic [31:0]          data_q;

  // Codeword position of data bit i: data fills the non-power-of-two slots 3,5,6,7,9,...
  function automatic logic [5:0] dpos(input int unsigned i);
    int unsigned n;
    logic [5:0]  r;
    n = 0;
    r = '0;
    for (int unsigned p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) r = 6'(p);
        n++;
      end
    end
    return r;
  endfunction

  logic              iord_req, accept, beat_emit;
  logic [WIDX_W-1:0] widx;
  logic [38:0]       word;
  logic [5:0]        syn;
  logic              pflag, ue_w, ce_w;
  logic [31:0]       cdata;

  assign iord_req  = sctag_scbuf_req_en_c7 & sctag_scbuf_ctag_c7[IORD_BIT];
  assign accept    = iord_req & ~jbi_scbuf_stall & ((state_q == IDLE) | (state_q == DONE));
  assign beat_emit = ~jbi_scbuf_stall & (state_q == DATA) & (cnt_q <= {1'b0, len_q});
  assign widx      = start_q + cnt_q[WIDX_W-1:0];
  assign word      = line_q[39*widx +: 39];

  // word = {data[31:0], pbit, check[5:0]}; syndrome is the codeword position of a single flip
  always_comb begin
    syn = word[5:0];
    for (int i = 0; i < 32; i++)
      if (word[7+i]) syn = syn ^ dpos(i);
    pflag = ^word;
    ce_w  = pflag;
    ue_w  = (|syn) & ~pflag;
    cdata = word[38:7];
    for (int i = 0; i < 32; i++)
      if (pflag && (dpos(i) == syn)) cdata[i] = ~cdata[i];
  end

  always_ff @(posedge rclk) begin
    if (accept) line_q <= scdata_scbuf_decc_out_c7;
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      ctag_q     <= '0;
      start_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      ctag_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      data_q     <= '0;
      ue_err_q   <= 1'b0;
      uerr_q     <= 1'b0;
      cerr_q     <= 1'b0;
      ue_acc_q   <= 1'b0;
      ce_acc_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (iord_req && !accept) ovf_q <= 1'b1;
      if (!jbi_scbuf_stall) begin
        case (state_q)
          IDLE, DONE: begin
            ctag_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            data_q     <= '0;
            ue_err_q   <= 1'b0;
            uerr_q     <= 1'b0;
            cerr_q     <= 1'b0;
            if (accept) begin
              state_q  <= CTAG;
              ctag_q   <= sctag_scbuf_ctag_c7;
              start_q  <= sctag_scbuf_word_c7;
              len_q    <= sctag_scbuf_len_m1_c7;
              cnt_q    <= '0;
              ue_acc_q <= 1'b0;
              ce_acc_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
          CTAG: begin
            ctag_vld_q             <= 1'b1;
            data_q                 <= '0;
            data_q[CTAG_W-1:0]     <= ctag_q;
            state_q                <= DATA;
          end
          DATA: begin
            ctag_vld_q <= 1'b0;
            if (beat_emit) begin
              data_vld_q <= 1'b1;
              data_q     <= cdata;
              ue_err_q   <= ue_w;
              ue_acc_q   <= ue_acc_q | ue_w;
              ce_acc_q   <= ce_acc_q | ce_w;
              cnt_q      <= cnt_q + 1'b1;
            end else begin
              data_vld_q <= 1'b0;
              data_q     <= '0;
              ue_err_q   <= 1'b0;
              uerr_q     <= ue_acc_q;
              cerr_q     <= ce_acc_q;
              state_q    <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef SCBUF_RDMARD_ERRCNT_EN
  logic [7:0] ce_cnt_q, ue_cnt_q;

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else if (beat_emit) begin
      if (ce_w && (ce_cnt_q != 8'hFF)) ce_cnt_q <= ce_cnt_q + 8'd1;
      if (ue_w && (ue_cnt_q != 8'hFF)) ue_cnt_q <= ue_cnt_q + 8'd1;
    end
  end

  assign scbuf_rdmard_ce_cnt = ce_cnt_q;
  assign scbuf_rdmard_ue_cnt = ue_cnt_q;
`else
  assign scbuf_rdmard_ce_cnt = '0;
  assign scbuf_rdmard_ue_cnt = '0;
`endif

  assign scbuf_sctag_rdmard_busy = (state_q != IDLE);
  assign scbuf_jbi_ctag_vld      = ctag_vld_q;
  assign scbuf_jbi_data_vld      = data_vld_q;
  assign scbuf_jbi_data          = data_q;
  assign scbuf_jbi_ue_err        = ue_err_q;
  assign scbuf_sctag_rdma_uerr   = uerr_q;
  assign scbuf_sctag_rdma_cerr   = cerr_q;
  assign scbuf_sctag_rdmard_ovf  = ovf_q;

endmodule

// File: tb/tb_scbuf_rdmard_burst.sv
// Directed bench for scbuf_rdmard_burst: vector table of bursts plus hand sequences for chaining, stall/overrun and reset.
module tb_scbuf_rdmard_burst;

  logic          rclk = 1'b0;
  logic          arst = 1'b1;
  logic          req_en = 1'b0;
  logic [14:0]   ctag_in = '0;
  logic [3:0]    word_in = '0;
  logic [3:0]    len_in = '0;
  logic [623:0]  line_in = '0;
  logic          stall = 1'b0;
  logic          busy, ctag_vld, data_vld, ue_err, uerr, cerr, ovf;
  logic [31:0]   data;
  logic [7:0]    ce_cnt, ue_cnt;

  scbuf_rdmard_burst dut (
    .rclk                     (rclk),
    .arst                     (arst),
    .sctag_scbuf_req_en_c7    (req_en),
    .sctag_scbuf_ctag_c7      (ctag_in),
    .sctag_scbuf_word_c7      (word_in),
    .sctag_scbuf_len_m1_c7    (len_in),
    .scdata_scbuf_decc_out_c7 (line_in),
    .jbi_scbuf_stall          (stall),
    .scbuf_sctag_rdmard_busy  (busy),
    .scbuf_jbi_ctag_vld       (ctag_vld),
    .scbuf_jbi_data_vld       (data_vld),
    .scbuf_jbi_data           (data),
    .scbuf_jbi_ue_err         (ue_err),
    .scbuf_sctag_rdma_uerr    (uerr),
    .scbuf_sctag_rdma_cerr    (cerr),
    .scbuf_sctag_rdmard_ovf   (ovf),
    .scbuf_rdmard_ce_cnt      (ce_cnt),
    .scbuf_rdmard_ue_cnt      (ue_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [14:0] ctag;
    logic [3:0]  start;
    logic [3:0]  len_m1;
    int          err_word;
    int          kind;      // 0 clean, 1 data single flip, 2 data double flip, 3 check-bit flip
    logic        exp_cerr;
    logic        exp_uerr;
  } vec_t;

  vec_t        vecs[8];
  int          checks = 0;
  int          errors = 0;
  int          ce_exp = 0;
  int          ue_exp = 0;
  int          beats_seen = 0;
  logic [5:0]  pos[32];
  logic [31:0] base[16];

  always @(negedge rclk)
    if (data_vld && !stall) beats_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] c;
    logic       p;
    c = '0;
    for (int i = 0; i < 32; i++)
      if (d[i]) c = c ^ pos[i];
    p = ^{d, c};
    return {d, p, c};
  endfunction

  function automatic logic [623:0] build_line(input int kind, input int ew);
    logic [623:0] l;
    for (int k = 0; k < 16; k++) l[39*k +: 39] = enc(base[k]);
    case (kind)
      1: l[39*ew + 12] = ~l[39*ew + 12];
      2: begin
        l[39*ew + 17] = ~l[39*ew + 17];
        l[39*ew + 27] = ~l[39*ew + 27];
      end
      3: l[39*ew] = ~l[39*ew];
      default: ;
    endcase
    return l;
  endfunction

  function automatic int exp_ce_cnt();
`ifdef SCBUF_RDMARD_ERRCNT_EN
    return ce_exp;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_ue_cnt();
`ifdef SCBUF_RDMARD_ERRCNT_EN
    return ue_exp;
`else
    return 0;
`endif
  endfunction

  task automatic start_req(input int v);
    req_en  = 1'b1;
    ctag_in = vecs[v].ctag;
    word_in = vecs[v].start;
    len_in  = vecs[v].len_m1;
    line_in = build_line(vecs[v].kind, vecs[v].err_word);
  endtask

  // Request inputs are already set in the current cycle; checks run through the DONE cycle.
  task automatic check_burst(input int v);
    int          w;
    logic [31:0] ed;
    logic        eu;
    @(posedge rclk); #1;
    req_en = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_ctag_vld", ctag_vld, 0);
    chk("c1_data_vld", data_vld, 0);
    @(posedge rclk); #1;
    chk("ctag_vld", ctag_vld, 1);
    chk("ctag_data", data, {17'b0, vecs[v].ctag});
    chk("ctag_beat_data_vld", data_vld, 0);
    for (int i = 0; i <= int'(vecs[v].len_m1); i++) begin
      @(posedge rclk); #1;
      w  = (int'(vecs[v].start) + i) % 16;
      eu = (vecs[v].kind == 2) && (w == vecs[v].err_word);
      ed = eu ? (base[w] ^ 32'h0010_0400) : base[w];
      if (w == vecs[v].err_word && (vecs[v].kind == 1 || vecs[v].kind == 3)) ce_exp++;
      if (eu) ue_exp++;
      chk($sformatf("v%0d_beat%0d_vld", v, i), data_vld, 1);
      chk($sformatf("v%0d_beat%0d_ctag_vld", v, i), ctag_vld, 0);
      chk($sformatf("v%0d_beat%0d_data", v, i), data, ed);
      chk($sformatf("v%0d_beat%0d_ue", v, i), ue_err, eu);
    end
    @(posedge rclk); #1;
    chk($sformatf("v%0d_done_vld", v), data_vld, 0);
    chk($sformatf("v%0d_done_busy", v), busy, 1);
    chk($sformatf("v%0d_done_cerr", v), cerr, vecs[v].exp_cerr);
    chk($sformatf("v%0d_done_uerr", v), uerr, vecs[v].exp_uerr);
  endtask

  task automatic check_idle(input string name);
    @(posedge rclk); #1;
    chk({name, "_busy"}, busy, 0);
    chk({name, "_cerr"}, cerr, 0);
    chk({name, "_uerr"}, uerr, 0);
  endtask

  initial begin
    int p;
    bit done;
    p = 0;
    for (int i = 0; i < 32; i++) begin
      do p++; while (p == 1 || p == 2 || p == 4 || p == 8 || p == 16 || p == 32);
      pos[i] = 6'(p);
    end
    for (int k = 0; k < 16; k++) base[k] = 32'h9E37_0000 ^ (32'(k) * 32'h0103_0507);

    vecs[0] = '{15'h1234,  4'd0, 4'd3, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{15'h1ABC, 4'd14, 4'd3, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{15'h1001,  4'd0, 4'd3, 2, 1, 1'b1, 1'b0};
    vecs[3] = '{15'h1002,  4'd0, 4'd3, 1, 2, 1'b0, 1'b1};
    vecs[4] = '{15'h7FFF,  4'd5, 4'd15, 0, 0, 1'b0, 1'b0};
    vecs[5] = '{15'h1555,  4'd9, 4'd0, 0, 0, 1'b0, 1'b0};
    vecs[6] = '{15'h1003,  4'd2, 4'd2, 3, 3, 1'b1, 1'b0};
    vecs[7] = '{15'h1004, 4'd15, 4'd1, 2, 1, 1'b0, 1'b0};

    repeat (3) @(posedge rclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ctag_vld", ctag_vld, 0);
    chk("rst_data_vld", data_vld, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", ovf, 0);
    arst = 1'b0;
    @(posedge rclk); #1;

    // IORD bit clear: ignored, not an overrun
    req_en = 1'b1; ctag_in = 15'h0234;
    @(posedge rclk); #1;
    req_en = 1'b0;
    chk("noiord_busy", busy, 0);
    @(posedge rclk); #1;
    chk("noiord_busy2", busy, 0);
    chk("noiord_ovf", ovf, 0);

    for (int v = 0; v < 8; v++) begin
      start_req(v);
      check_burst(v);
      check_idle($sformatf("v%0d_after", v));
    end
    chk("table_ovf", ovf, 0);
    chk("table_ce_cnt", ce_cnt, exp_ce_cnt());
    chk("table_ue_cnt", ue_cnt, exp_ue_cnt());

    // back-to-back: second request issued in the DONE cycle
    start_req(5);
    check_burst(5);
    start_req(1);
    check_burst(1);
    check_idle("chain_after");
    chk("chain_ovf", ovf, 0);

    // stall during beat 1 plus an overrun request
    start_req(0);
    beats_seen = 0;
    @(posedge rclk); #1; req_en = 1'b0;
    @(posedge rclk); #1;
    @(posedge rclk); #1;
    chk("stall_beat0", data, base[0]);
    @(posedge rclk); #1;
    chk("stall_beat1", data, base[1]);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge rclk); #1;
      chk($sformatf("stall_hold%0d_data", k), data, base[1]);
      chk($sformatf("stall_hold%0d_vld", k), data_vld, 1);
      if (k == 0) begin req_en = 1'b1; ctag_in = 15'h1FFF; end
      if (k == 1) begin req_en = 1'b0; chk("ovr_ovf_set", ovf, 1); end
      if (k == 2) stall = 1'b0;
    end
    @(posedge rclk); #1;
    chk("stall_beat2", data, base[2]);
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(posedge rclk); #1;
      if (!busy) done = 1'b1;
    end
    chk("stall_finished", done, 1);
    chk("stall_beat_count", beats_seen, 4);
    start_req(5);
    check_burst(5);
    check_idle("ovf_sticky_after");
    chk("ovf_sticky", ovf, 1);

    // async reset mid-DATA
    start_req(2);
    @(posedge rclk); #1; req_en = 1'b0;
    repeat (4) @(posedge rclk);
    #3 arst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_data_vld", data_vld, 0);
    chk("arst_data", data, 0);
    chk("arst_ue", ue_err, 0);
    chk("arst_cerr", cerr, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_ce_cnt", ce_cnt, 0);
    ce_exp = 0;
    ue_exp = 0;
    @(posedge rclk); #1;
    chk("arst_hold_cerr", cerr, 0);
    arst = 1'b0;
    @(posedge rclk); #1;
    start_req(2);
    check_burst(2);
    check_idle("post_arst_after");
    start_req(3);
    check_burst(3);
    check_idle("post_arst3_after");
    chk("post_arst_ce_cnt", ce_cnt, exp_ce_cnt());
    chk("post_arst_ue_cnt", ue_cnt, exp_ue_cnt());
    chk("post_arst_ovf", ovf, 0);

    // stall in IDLE blocks acceptance and counts as overrun
    stall = 1'b1; start_req(0);
    @(posedge rclk); #1;
    req_en = 1'b0;
    chk("idle_stall_busy", busy, 0);
    chk("idle_stall_ovf", ovf, 1);
    stall = 1'b0;
    @(posedge rclk); #1;
    chk("idle_stall_busy2", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
